instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the processor control unit. Holds a 16-word × 5-bit program memory, loaded through a write port. Maintains the 4-bit program counter and presents one instruction at a time as `Opcode`/`Reg_Addr`. Advances only when the control unit asserts `PC_En`.

---
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: 16x5 program memory, 4-bit PC, one instruction held per issue slot.
// One-cycle fetch latency with a bubble per instruction; control unit advances via PC_En.
module instr_fetch_unit #(
  parameter int PC_W    = 4,
  parameter int DEPTH   = 2 ** PC_W,
  parameter int INSTR_W = 5
) (
  input  logic               Clk,
  input  logic               Rst_N,
  input  logic               Load_En,
  input  logic [PC_W-1:0]    Load_Addr,
  input  logic [INSTR_W-1:0] Load_Data,
  input  logic               Run,
  input  logic               PC_En,
  input  logic               Branch_En,
  input  logic [PC_W-1:0]    Branch_Addr,
  output logic [1:0]         Opcode,
  output logic [2:0]         Reg_Addr,
  output logic [PC_W-1:0]    PC,
  output logic               Instr_Valid,
  output logic               Halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [PC_W-1:0]      pc_q, pc_nxt;
  logic [INSTR_W-1:0]   ir_q, ir_nxt;
  logic                 valid_q, valid_nxt;
  logic                 halted_q, halted_nxt;
  logic                 mem_we;
  logic [INSTR_W-1:0]   mem [DEPTH];

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - 1);

  // Program memory is deliberately left out of reset so a reset does not wipe the program.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[Load_Addr] <= Load_Data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state    <= IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      ir_q     <= ir_nxt;
      valid_q  <= valid_nxt;
      halted_q <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    ir_nxt     = ir_q;
    valid_nxt  = valid_q;
    halted_nxt = halted_q;
    mem_we     = 1'b0;
    case (state)
      IDLE, HALT: begin
        // A load in the same cycle as Run takes priority and Run is dropped.
        if (Load_En) begin
          mem_we = 1'b1;
        end else if (Run) begin
          pc_nxt     = '0;
          halted_nxt = 1'b0;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        ir_nxt    = mem[pc_q];
        valid_nxt = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (PC_En) begin
          valid_nxt = 1'b0;
          if (Branch_En) begin
            pc_nxt    = Branch_Addr;
            state_nxt = FETCH;
          end else if (pc_q == LAST_PC) begin
            pc_nxt     = '0;
            halted_nxt = 1'b1;
            state_nxt  = HALT;
          end else begin
            pc_nxt    = pc_q + PC_W'(1);
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Opcode      = ir_q[INSTR_W-1 -: 2];
  assign Reg_Addr    = ir_q[2:0];
  assign PC          = pc_q;
  assign Instr_Valid = valid_q;
  assign Halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected issues queued by stimulus, popped by a monitor.
module tb_instr_fetch_unit;

  logic       Clk = 1'b0;
  logic       Rst_N = 1'b0;
  logic       Load_En = 1'b0;
  logic [3:0] Load_Addr = '0;
  logic [4:0] Load_Data = '0;
  logic       Run = 1'b0;
  logic       PC_En = 1'b0;
  logic       Branch_En = 1'b0;
  logic [3:0] Branch_Addr = '0;
  logic [1:0] Opcode;
  logic [2:0] Reg_Addr;
  logic [3:0] PC;
  logic       Instr_Valid;
  logic       Halted;

  instr_fetch_unit dut (
    .Clk(Clk), .Rst_N(Rst_N), .Load_En(Load_En), .Load_Addr(Load_Addr),
    .Load_Data(Load_Data), .Run(Run), .PC_En(PC_En), .Branch_En(Branch_En),
    .Branch_Addr(Branch_Addr), .Opcode(Opcode), .Reg_Addr(Reg_Addr), .PC(PC),
    .Instr_Valid(Instr_Valid), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];
  logic [8:0] mon_exp;
  logic       prev_valid = 1'b0;

  // Program image; words 0 and 1 are 01_010 and 10_101.
  logic [4:0] prog [16] = '{5'h0A, 5'h15, 5'h07, 5'h18, 5'h04, 5'h1F, 5'h11, 5'h02,
                            5'h0C, 5'h13, 5'h1B, 5'h09, 5'h16, 5'h0E, 5'h01, 5'h1D};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every new issue slot (rising Instr_Valid) is matched against the queue.
  always @(posedge Clk) begin
    #2;
    if (Instr_Valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: got pc %0d instr %0h expected no issue", PC, {Opcode, Reg_Addr});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("issue", {23'd0, PC, Opcode, Reg_Addr}, {23'd0, mon_exp});
      end
    end
    prev_valid = Instr_Valid;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_issue(input logic [3:0] pc);
    exp_q.push_back({pc, prog[pc]});
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!Instr_Valid && n < 6) begin
      step();
      n++;
    end
    chk(name, {31'd0, Instr_Valid}, 32'd1);
  endtask

  task automatic advance(input logic br, input logic [3:0] tgt, input logic [3:0] exp_pc, input logic issues);
    Branch_En   = br;
    Branch_Addr = tgt;
    PC_En       = 1'b1;
    if (issues) expect_issue(exp_pc);
    step();
    PC_En     = 1'b0;
    Branch_En = 1'b0;
    chk("bubble", {31'd0, Instr_Valid}, 32'd0);
    if (issues) wait_valid("next_valid");
  endtask

  initial begin
    repeat (2) step();
    chk("reset_outputs", {21'd0, PC, Opcode, Reg_Addr, Instr_Valid, Halted}, 32'd0);
    Rst_N = 1'b1;
    step();

    // Load the program; Run on the last load cycle must be ignored.
    for (int i = 0; i < 16; i++) begin
      Load_En   = 1'b1;
      Load_Addr = 4'(i);
      Load_Data = prog[i];
      Run       = (i == 15);
      step();
    end
    Load_En = 1'b0;
    Run     = 1'b0;
    chk("load_wins_a", {31'd0, Instr_Valid}, 32'd0);
    step();
    chk("load_wins_b", {31'd0, Instr_Valid}, 32'd0);

    Run = 1'b1;
    expect_issue(4'd0);
    step();
    Run = 1'b0;
    chk("run_fetch_bubble", {27'd0, PC, Instr_Valid}, 32'd0);
    wait_valid("run_valid");

    for (int i = 0; i < 10; i++) begin
      Branch_En   = i[0];
      Branch_Addr = 4'd9;
      step();
      chk("hold", {22'd0, PC, Opcode, Reg_Addr, Instr_Valid}, {22'd0, 4'd0, prog[0], 1'b1});
    end
    Branch_En = 1'b0;

    // Write attempt during ISSUE; mem[2] must keep its original word.
    Load_En   = 1'b1;
    Load_Addr = 4'd2;
    Load_Data = 5'h00;
    step();
    Load_En = 1'b0;

    advance(1'b0, 4'd0, 4'd1, 1'b1);
    advance(1'b0, 4'd0, 4'd2, 1'b1);
    advance(1'b0, 4'd0, 4'd3, 1'b1);
    advance(1'b1, 4'd12, 4'd12, 1'b1);
    advance(1'b0, 4'd0, 4'd13, 1'b1);
    advance(1'b0, 4'd0, 4'd14, 1'b1);
    advance(1'b0, 4'd0, 4'd15, 1'b1);
    advance(1'b1, 4'd2, 4'd2, 1'b1);
    chk("branch_from_15_no_halt", {31'd0, Halted}, 32'd0);
    for (int p = 3; p < 16; p++) begin
      advance(1'b0, 4'd0, 4'(p), 1'b1);
    end

    advance(1'b0, 4'd0, 4'd0, 1'b0);
    chk("halt_entry", {21'd0, Halted, PC, Instr_Valid, Opcode, Reg_Addr}, {21'd0, 1'b1, 4'd0, 1'b0, prog[15]});
    PC_En = 1'b1;
    step();
    step();
    PC_En = 1'b0;
    chk("halt_ignores_pc_en", {21'd0, Halted, PC, Instr_Valid, Opcode, Reg_Addr}, {21'd0, 1'b1, 4'd0, 1'b0, prog[15]});

    Run = 1'b1;
    expect_issue(4'd0);
    step();
    Run = 1'b0;
    chk("restart_clears_halted", {31'd0, Halted}, 32'd0);
    wait_valid("restart_valid");

    advance(1'b0, 4'd0, 4'd1, 1'b1);
    @(posedge Clk);
    #3;
    Rst_N = 1'b0;
    #1;
    chk("async_reset", {21'd0, PC, Opcode, Reg_Addr, Instr_Valid, Halted}, 32'd0);
    step();
    Rst_N = 1'b1;
    step();
    step();
    chk("idle_after_reset", {31'd0, Instr_Valid}, 32'd0);
    Run = 1'b1;
    expect_issue(4'd0);
    step();
    Run = 1'b0;
    wait_valid("rerun_after_reset");

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
